// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter sequencer and instruction-fetch handshake.
//
// Owns the PC. Issues one instruction-memory read at a time. Hands fetched
// words to decode over a valid/ready pair. Applies branch redirects, which
// squash in-flight or held words, and parks in HALT on request.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   fetch_req/fetch_addr     memory read request, address (always == pc)
//   fetch_ack/fetch_data     memory response
//   instr_valid/instr        held instruction for decode
//   instr_ready              decode consumes instr
//   branch_valid/_target     one-cycle PC redirect from execute
//   halt                     level request to stop fetching
//   pc_sel/pc_load           PC mux select / PC load strobe (combinational)
//   pc, halted               current PC, HALT indicator
//
// state | meaning
// BOOT  | one idle cycle after reset
// FETCH | read outstanding at pc, waiting for fetch_ack
// HOLD  | fetched word presented to decode, waiting for instr_ready
// HALT  | fetching stopped until halt drops

module pc_fetch_ctrl #(
   parameter int unsigned          WIDTH     = 16,
   parameter logic [WIDTH-1:0]     RESET_VEC = '0,
   parameter int unsigned          INC       = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             fetch_req,
   output logic [WIDTH-1:0] fetch_addr,
   input  logic             fetch_ack,
   input  logic [WIDTH-1:0] fetch_data,
   output logic             instr_valid,
   output logic [WIDTH-1:0] instr,
   input  logic             instr_ready,
   input  logic             branch_valid,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             halt,
   output logic             pc_sel,
   output logic             pc_load,
   output logic [WIDTH-1:0] pc,
   output logic             halted
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic             instr_valid_q, instr_valid_d;
   logic             br_pend_q, br_pend_d;
   logic [WIDTH-1:0] br_tgt_q, br_tgt_d;
   logic [WIDTH-1:0] pc_target;
   state_t           exit_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_BOOT;
         pc_q          <= RESET_VEC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         br_pend_q     <= 1'b0;
         br_tgt_q      <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         br_pend_q     <= br_pend_d;
         br_tgt_q      <= br_tgt_d;
      end
   end

   // A branch arriving on the ack cycle is newer than the pending one.
   assign pc_target  = (state_q == S_FETCH && !branch_valid && br_pend_q) ? br_tgt_q : branch_target;
   assign exit_state = halt ? S_HALT : S_FETCH;

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      br_pend_d     = br_pend_q;
      br_tgt_d      = br_tgt_q;
      pc_load       = 1'b0;
      pc_sel        = 1'b0;

      case (state_q)
         S_BOOT: begin
            if (branch_valid) begin
               pc_load = 1'b1;
               pc_sel  = 1'b1;
            end
            state_d = exit_state;
         end
         S_FETCH: begin
            if (fetch_ack) begin
               br_pend_d = 1'b0;
               pc_load   = 1'b1;
               if (branch_valid || br_pend_q) begin
                  pc_sel  = 1'b1;
                  state_d = exit_state;
               end else begin
                  instr_d       = fetch_data;
                  instr_valid_d = 1'b1;
                  state_d       = S_HOLD;
               end
            end else if (branch_valid) begin
               br_pend_d = 1'b1;
               br_tgt_d  = branch_target;
            end
         end
         S_HOLD: begin
            if (branch_valid) begin
               instr_valid_d = 1'b0;
               pc_load       = 1'b1;
               pc_sel        = 1'b1;
               state_d       = exit_state;
            end else if (instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = exit_state;
            end
         end
         S_HALT: begin
            if (branch_valid) begin
               pc_load = 1'b1;
               pc_sel  = 1'b1;
            end
            if (!halt) begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_BOOT;
      endcase

      if (!pc_load) begin
         pc_d = pc_q;
      end else if (pc_sel) begin
         pc_d = pc_target;
      end else begin
         pc_d = pc_q + INC_W;
      end
   end

   assign fetch_req   = (state_q == S_FETCH);
   assign fetch_addr  = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ack;
   logic [15:0] fetch_data;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic        branch_valid;
   logic [15:0] branch_target;
   logic        halt;
   logic        pc_sel;
   logic        pc_load;
   logic [15:0] pc;
   logic        halted;

   int n_cmp = 0;
   int n_bad = 0;

   pc_fetch_ctrl #(.WIDTH(16), .RESET_VEC(16'h0000), .INC(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ack(fetch_ack), .fetch_data(fetch_data),
      .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .halt(halt), .pc_sel(pc_sel), .pc_load(pc_load),
      .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; fetch_ack = 0; fetch_data = '0; instr_ready = 0;
      branch_valid = 0; branch_target = '0; halt = 0;
      tick(); tick();
      n_cmp++; if (fetch_req !== 1'b0) begin n_bad++; $display("FAIL rst_fetch_req: got %b want 0", fetch_req); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
      n_cmp++; if (instr !== 16'h0000) begin n_bad++; $display("FAIL rst_instr: got %h want 0000", instr); end
      n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL rst_pc: got %h want 0000", pc); end
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted); end
      n_cmp++; if ({pc_sel, pc_load} !== 2'b00) begin n_bad++; $display("FAIL rst_pc_ctl: got %b want 00", {pc_sel, pc_load}); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (fetch_req !== 1'b0) begin n_bad++; $display("FAIL boot_idle: got %b want 0", fetch_req); end
      tick();
      n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000) begin n_bad++; $display("FAIL boot_first_fetch: got req %b addr %h want 1 0000", fetch_req, fetch_addr); end
   endtask

   task automatic test_sequential();
      instr_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'(k)) begin n_bad++; $display("FAIL seq_req: got req %b addr %h want 1 %h", fetch_req, fetch_addr, 16'(k)); end
         tick();
         n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'(k)) begin n_bad++; $display("FAIL seq_req_hold: got req %b addr %h want 1 %h", fetch_req, fetch_addr, 16'(k)); end
         fetch_ack = 1'b1; fetch_data = 16'(k) ^ 16'hA5A5;
         #1;
         n_cmp++; if ({pc_sel, pc_load} !== 2'b01) begin n_bad++; $display("FAIL seq_pc_ctl: got %b want 01", {pc_sel, pc_load}); end
         tick();
         fetch_ack = 1'b0;
         n_cmp++; if (instr_valid !== 1'b1 || instr !== (16'(k) ^ 16'hA5A5)) begin n_bad++; $display("FAIL seq_instr: got v%b %h want v1 %h", instr_valid, instr, 16'(k) ^ 16'hA5A5); end
         n_cmp++; if (fetch_req !== 1'b0 || pc !== 16'(k + 1)) begin n_bad++; $display("FAIL seq_hold: got req %b pc %h want 0 %h", fetch_req, pc, 16'(k + 1)); end
         tick();
      end
      instr_ready = 1'b0;
   endtask

   task automatic test_wrap();
      branch_valid = 1'b1; branch_target = 16'hFFFF;
      tick();
      branch_valid = 1'b0; fetch_ack = 1'b1; fetch_data = 16'h1111;
      #1;
      n_cmp++; if ({pc_sel, pc_load} !== 2'b11) begin n_bad++; $display("FAIL wrap_preset_ctl: got %b want 11", {pc_sel, pc_load}); end
      tick();
      fetch_ack = 1'b0;
      n_cmp++; if (instr_valid !== 1'b0 || pc !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preset: got v%b pc %h want v0 FFFF", instr_valid, pc); end
      n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_req: got req %b addr %h want 1 FFFF", fetch_req, fetch_addr); end
      fetch_ack = 1'b1; fetch_data = 16'hFFFF ^ 16'hA5A5;
      #1;
      n_cmp++; if ({pc_sel, pc_load} !== 2'b01) begin n_bad++; $display("FAIL wrap_ctl: got %b want 01", {pc_sel, pc_load}); end
      tick();
      fetch_ack = 1'b0;
      n_cmp++; if (pc !== 16'h0000 || instr !== 16'h5A5A || instr_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_pc: got pc %h instr %h v%b want 0000 5A5A v1", pc, instr, instr_valid); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000) begin n_bad++; $display("FAIL wrap_next: got req %b addr %h want 1 0000", fetch_req, fetch_addr); end
   endtask

   task automatic test_branch_pending();
      tick(); tick();
      branch_valid = 1'b1; branch_target = 16'h0100;
      tick();
      branch_valid = 1'b0;
      n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000 || pc !== 16'h0000) begin n_bad++; $display("FAIL bp_hold: got req %b addr %h pc %h want 1 0000 0000", fetch_req, fetch_addr, pc); end
      tick();
      fetch_ack = 1'b1; fetch_data = 16'hDEAD;
      #1;
      n_cmp++; if ({pc_sel, pc_load} !== 2'b11) begin n_bad++; $display("FAIL bp_ctl: got %b want 11", {pc_sel, pc_load}); end
      tick();
      fetch_ack = 1'b0;
      n_cmp++; if (instr_valid !== 1'b0 || pc !== 16'h0100) begin n_bad++; $display("FAIL bp_squash: got v%b pc %h want v0 0100", instr_valid, pc); end
      n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0100) begin n_bad++; $display("FAIL bp_next: got req %b addr %h want 1 0100", fetch_req, fetch_addr); end
      branch_valid = 1'b1; branch_target = 16'h0200;
      tick();
      branch_target = 16'h0300; fetch_ack = 1'b1; fetch_data = 16'hBEEF;
      tick();
      branch_valid = 1'b0; fetch_ack = 1'b0;
      n_cmp++; if (pc !== 16'h0300 || fetch_addr !== 16'h0300 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL bp_latest: got pc %h addr %h v%b want 0300 0300 v0", pc, fetch_addr, instr_valid); end
   endtask

   task automatic test_backpressure();
      fetch_ack = 1'b1; fetch_data = 16'h1234;
      tick();
      fetch_ack = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || fetch_req !== 1'b0 || pc !== 16'h0301) begin n_bad++; $display("FAIL bpress_hold: got v%b %h req %b pc %h want v1 1234 0 0301", instr_valid, instr, fetch_req, pc); end
         tick();
      end
      branch_valid = 1'b1; branch_target = 16'h0500; instr_ready = 1'b1;
      #1;
      n_cmp++; if ({pc_sel, pc_load} !== 2'b11) begin n_bad++; $display("FAIL bpress_ctl: got %b want 11", {pc_sel, pc_load}); end
      tick();
      branch_valid = 1'b0; instr_ready = 1'b0;
      n_cmp++; if (instr_valid !== 1'b0 || pc !== 16'h0500 || fetch_req !== 1'b1 || fetch_addr !== 16'h0500) begin n_bad++; $display("FAIL bpress_squash: got v%b pc %h req %b addr %h want v0 0500 1 0500", instr_valid, pc, fetch_req, fetch_addr); end
   endtask

   task automatic test_halt();
      halt = 1'b1;
      tick();
      n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0500 || halted !== 1'b0) begin n_bad++; $display("FAIL halt_outstanding: got req %b addr %h halted %b want 1 0500 0", fetch_req, fetch_addr, halted); end
      fetch_ack = 1'b1; fetch_data = 16'h0BEE;
      tick();
      fetch_ack = 1'b0;
      n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'h0BEE || halted !== 1'b0 || fetch_req !== 1'b0) begin n_bad++; $display("FAIL halt_deliver: got v%b %h halted %b req %b want v1 0BEE 0 0", instr_valid, instr, halted, fetch_req); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      tick();
      n_cmp++; if (halted !== 1'b1 || fetch_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL halt_state: got halted %b req %b v%b want 1 0 0", halted, fetch_req, instr_valid); end
      branch_valid = 1'b1; branch_target = 16'h0040;
      #1;
      n_cmp++; if ({pc_sel, pc_load} !== 2'b11) begin n_bad++; $display("FAIL halt_br_ctl: got %b want 11", {pc_sel, pc_load}); end
      tick();
      branch_valid = 1'b0;
      n_cmp++; if (pc !== 16'h0040 || halted !== 1'b1) begin n_bad++; $display("FAIL halt_br: got pc %h halted %b want 0040 1", pc, halted); end
      halt = 1'b0;
      tick();
      n_cmp++; if (halted !== 1'b0 || fetch_req !== 1'b1 || fetch_addr !== 16'h0040) begin n_bad++; $display("FAIL halt_resume: got halted %b req %b addr %h want 0 1 0040", halted, fetch_req, fetch_addr); end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (fetch_req !== 1'b0 || pc !== 16'h0000 || instr !== 16'h0000 || instr_valid !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL rstmid_fetch: got req %b pc %h instr %h v%b halted %b want 0 0000 0000 0 0", fetch_req, pc, instr, instr_valid, halted); end
      #1 rst_n = 1'b1;
      #1;
      n_cmp++; if (fetch_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_boot: got req %b want 0", fetch_req); end
      tick();
      n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000) begin n_bad++; $display("FAIL rstmid_refetch: got req %b addr %h want 1 0000", fetch_req, fetch_addr); end
      fetch_ack = 1'b1; fetch_data = 16'h7777;
      tick();
      fetch_ack = 1'b0;
      n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'h7777) begin n_bad++; $display("FAIL rstmid_hold: got v%b %h want v1 7777", instr_valid, instr); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || pc !== 16'h0000 || fetch_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_inhold: got v%b instr %h pc %h req %b want 0 0000 0000 0", instr_valid, instr, pc, fetch_req); end
      #1 rst_n = 1'b1;
      tick();
      n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000) begin n_bad++; $display("FAIL rstmid_refetch2: got req %b addr %h want 1 0000", fetch_req, fetch_addr); end
   endtask

   // Transaction-level scoreboard: tracks the address the next read must use,
   // a redirect seen while a read is in flight, and the word owed to decode.
   task automatic test_random();
      logic        exp_req = 1'b1, exp_valid = 1'b0, in_req = 1'b0, redir = 1'b0;
      logic [15:0] exp_addr = 16'h0000, req_addr = '0, exp_instr = '0, rtgt = '0;
      logic        br, rdy, ack, exp_load, exp_sel;
      logic [15:0] tgt, dat;
      for (int cyc = 0; cyc < 600; cyc++) begin
         n_cmp++; if (fetch_req !== exp_req || instr_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_handshake cyc %0d: got req %b v%b want %b v%b", cyc, fetch_req, instr_valid, exp_req, exp_valid); end
         n_cmp++; if (fetch_addr !== pc) begin n_bad++; $display("FAIL rnd_addr_pc cyc %0d: got addr %h pc %h", cyc, fetch_addr, pc); end
         if (exp_valid) begin
            n_cmp++; if (instr !== exp_instr) begin n_bad++; $display("FAIL rnd_instr cyc %0d: got %h want %h", cyc, instr, exp_instr); end
         end
         if (exp_req) begin
            if (!in_req) begin
               in_req = 1'b1; req_addr = exp_addr;
            end
            n_cmp++; if (fetch_addr !== req_addr) begin n_bad++; $display("FAIL rnd_req_addr cyc %0d: got %h want %h", cyc, fetch_addr, req_addr); end
         end
         br  = ($urandom_range(0, 7) == 0);
         tgt = 16'($urandom);
         rdy = ($urandom_range(0, 2) != 0);
         ack = exp_req && ($urandom_range(0, 2) == 0);
         dat = 16'($urandom);
         branch_valid = br; branch_target = tgt; instr_ready = rdy;
         fetch_ack = ack; fetch_data = dat;
         exp_load = 1'b0; exp_sel = 1'b0;
         if (exp_req) begin
            if (br) begin redir = 1'b1; rtgt = tgt; end
            if (ack) begin
               exp_load = 1'b1; exp_sel = redir; in_req = 1'b0;
               if (redir) begin
                  exp_addr = rtgt; redir = 1'b0;
               end else begin
                  exp_instr = dat; exp_valid = 1'b1; exp_req = 1'b0;
                  exp_addr = req_addr + 16'd1;
               end
            end
         end else if (exp_valid) begin
            if (br) begin
               exp_load = 1'b1; exp_sel = 1'b1;
               exp_addr = tgt; exp_valid = 1'b0; exp_req = 1'b1;
            end else if (rdy) begin
               exp_valid = 1'b0; exp_req = 1'b1;
            end
         end
         #1;
         n_cmp++; if (pc_load !== exp_load || pc_sel !== exp_sel) begin n_bad++; $display("FAIL rnd_pc_ctl cyc %0d: got load %b sel %b want %b %b", cyc, pc_load, pc_sel, exp_load, exp_sel); end
         tick();
      end
      branch_valid = 0; fetch_ack = 0; instr_ready = 0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wrap();
      test_branch_pending();
      test_backpressure();
      test_halt();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
